// File: rtl/input_msg_framer_if.sv
// input_msg_framer_if: word-stream input, read port and status/event outputs of the message framer.
// Latency: none (wires only).
// Backpressure: none carried here; the framer reports drops on ERR_OVF/ERR_FMT.
interface input_msg_framer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_ENA;
  logic              RD_REQ;
  logic [DATA_W-1:0] RD_DATA;
  logic              RD_VALID;
  logic              MSG_READY;
  logic [7:0]        MSG_LEN;
  logic              TYPE_VER;
  logic              ERR_FMT;
  logic              ERR_OVF;

  // Producer/consumer side (testbench, upstream deserializer and downstream router)
  modport master (
    output IN_DATA, IN_ENA, RD_REQ,
    input  RD_DATA, RD_VALID, MSG_READY, MSG_LEN, TYPE_VER, ERR_FMT, ERR_OVF
  );

  // Framer side
  modport slave (
    input  IN_DATA, IN_ENA, RD_REQ,
    output RD_DATA, RD_VALID, MSG_READY, MSG_LEN, TYPE_VER, ERR_FMT, ERR_OVF
  );
endinterface

// File: rtl/input_msg_framer.sv
// input_msg_framer: parses prefix/cmd/len/data/chk words into whole messages in a circular buffer.
// Latency: commit shows on MSG_READY the cycle after the last word; RD_DATA 1 cycle after RD_REQ.
// Backpressure: input never stalls, full buffer/length FIFO drops the message with ERR_OVF.
// Optional feature macro CHKSUM_CHECK_EN: compare the checksum word and drop on mismatch.
module input_msg_framer #(
  parameter int                DATA_W  = 16,
  parameter logic [DATA_W-1:0] PREFIX  = 16'h55AA,
  parameter int                BUF_AW  = 8,
  parameter int                LF_AW   = 3,
  parameter int                MAX_LEN = 64
) (
  input logic               SYS_CLK,
  input logic               RST,
  input_msg_framer_if.slave bus
);
  localparam int BUF_D = 1 << BUF_AW;
  localparam int LF_D  = 1 << LF_AW;

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_DATA, S_CHK} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [BUF_D];
  logic [7:0]          r_lf_mem [LF_D];
  logic [BUF_AW-1:0]   r_wr_ptr, r_wr_commit, r_rd_ptr;
  logic [DATA_W-1:0]   r_cmd, r_sum, r_rd_data;
  logic                r_has_chk;
  logic [7:0]          r_len, r_cnt, r_msg_cnt, r_rd_cnt;
  logic [LF_AW-1:0]    r_lf_wr, r_lf_rd;
  logic [LF_AW:0]      r_lf_cnt;
  logic                r_rd_valid, r_type_ver, r_err_fmt, r_err_ovf;

  logic                w_buf_full, w_lf_full, w_lf_empty;
  logic                w_rd_acc, w_rd_last;
  logic [7:0]          w_head_len, w_tbl_len;
  logic                w_wr_en, w_last, w_commit, w_bad_fmt, w_ovf;
  logic [DATA_W-1:0]   w_cur_cmd;

  assign w_buf_full = (r_wr_ptr + BUF_AW'(1)) == r_rd_ptr;
  assign w_lf_full  = r_lf_cnt == (LF_AW+1)'(LF_D);
  assign w_lf_empty = r_lf_cnt == '0;
  assign w_head_len = r_lf_mem[r_lf_rd];
  assign w_rd_acc   = bus.RD_REQ && !w_lf_empty;
  assign w_rd_last  = w_rd_acc && (r_rd_cnt == w_head_len - 8'd1);
  assign w_cur_cmd  = (r_state == S_CMD) ? bus.IN_DATA : r_cmd;

  // Implied data length for commands that carry no len word
  always_comb begin
    w_tbl_len = 8'd0;
    if (bus.IN_DATA == DATA_W'(16'h0140))      w_tbl_len = 8'd2;
    else if (bus.IN_DATA == DATA_W'(16'h0300)) w_tbl_len = 8'd16;
  end

  // Per-word decision: store, finish (commit), or drop with format/overflow error
  always_comb begin
    w_wr_en   = 1'b0;
    w_last    = 1'b0;
    w_commit  = 1'b0;
    w_bad_fmt = 1'b0;
    w_ovf     = 1'b0;
    if (bus.IN_ENA) begin
      if (r_state == S_HUNT) begin
        if (bus.IN_DATA == PREFIX) begin
          if (w_buf_full) w_ovf = 1'b1;
          else            w_wr_en = 1'b1;
        end
      end else if (w_buf_full) begin
        w_ovf = 1'b1;
      end else begin
        w_wr_en = 1'b1;
        case (r_state)
          S_CMD:  w_last = !bus.IN_DATA[0] && (w_tbl_len == 8'd0) && !bus.IN_DATA[1];
          S_LEN: begin
            if (bus.IN_DATA[7:0] > 8'(MAX_LEN)) begin
              w_bad_fmt = 1'b1;
              w_wr_en   = 1'b0;
            end else begin
              w_last = (bus.IN_DATA[7:0] == 8'd0) && !r_has_chk;
            end
          end
          S_DATA: w_last = (r_cnt == r_len - 8'd1) && !r_has_chk;
          S_CHK: begin
`ifdef CHKSUM_CHECK_EN
            if (bus.IN_DATA != r_sum) begin
              w_bad_fmt = 1'b1;
              w_wr_en   = 1'b0;
            end else begin
              w_last = 1'b1;
            end
`else
            w_last = 1'b1;
`endif
          end
          default: w_last = 1'b0;
        endcase
      end
      // A finished message with no room in the length FIFO is lost like any other overflow
      if (w_last) begin
        if (w_lf_full) begin
          w_ovf   = 1'b1;
          w_wr_en = 1'b0;
        end else begin
          w_commit = 1'b1;
        end
      end
    end
  end

  // Storage arrays: message words and committed lengths (no reset needed)
  always_ff @(posedge SYS_CLK) begin
    if (w_wr_en)  r_mem[r_wr_ptr]   <= bus.IN_DATA;
    if (w_commit) r_lf_mem[r_lf_wr] <= r_msg_cnt + 8'd1;
  end

  // Parser FSM: speculative write pointer, commit/rollback and event pulses
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_HUNT;
      r_wr_ptr    <= '0;
      r_wr_commit <= '0;
      r_cmd       <= '0;
      r_sum       <= '0;
      r_has_chk   <= 1'b0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_msg_cnt   <= '0;
      r_type_ver  <= 1'b0;
      r_err_fmt   <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_type_ver <= 1'b0;
      r_err_fmt  <= 1'b0;
      r_err_ovf  <= 1'b0;
      if (w_commit) begin
        r_wr_ptr    <= r_wr_ptr + BUF_AW'(1);
        r_wr_commit <= r_wr_ptr + BUF_AW'(1);
        r_type_ver  <= w_cur_cmd == DATA_W'(16'h0140);
        r_state     <= S_HUNT;
      end else if (w_bad_fmt || w_ovf) begin
        r_wr_ptr  <= r_wr_commit;
        r_err_fmt <= w_bad_fmt;
        r_err_ovf <= w_ovf;
        r_state   <= S_HUNT;
      end else if (bus.IN_ENA) begin
        if (w_wr_en) r_wr_ptr <= r_wr_ptr + BUF_AW'(1);
        case (r_state)
          S_HUNT: begin
            if (w_wr_en) begin
              r_msg_cnt <= 8'd1;
              r_state   <= S_CMD;
            end
          end
          S_CMD: begin
            r_cmd     <= bus.IN_DATA;
            r_has_chk <= bus.IN_DATA[1];
            r_sum     <= bus.IN_DATA;
            r_msg_cnt <= 8'd2;
            r_cnt     <= 8'd0;
            if (bus.IN_DATA[0]) begin
              r_state <= S_LEN;
            end else begin
              r_len   <= w_tbl_len;
              r_state <= (w_tbl_len == 8'd0) ? S_CHK : S_DATA;
            end
          end
          S_LEN: begin
            r_len     <= bus.IN_DATA[7:0];
            r_sum     <= r_sum + bus.IN_DATA;
            r_msg_cnt <= r_msg_cnt + 8'd1;
            r_state   <= (bus.IN_DATA[7:0] == 8'd0) ? S_CHK : S_DATA;
          end
          S_DATA: begin
            r_sum     <= r_sum + bus.IN_DATA;
            r_msg_cnt <= r_msg_cnt + 8'd1;
            if (r_cnt == r_len - 8'd1) r_state <= S_CHK;
            else                       r_cnt   <= r_cnt + 8'd1;
          end
          default: r_state <= S_HUNT;
        endcase
      end
    end
  end

  // Read side and length FIFO bookkeeping; a commit and a last-word pop may coincide
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_rd_ptr   <= '0;
      r_rd_cnt   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_lf_wr    <= '0;
      r_lf_rd    <= '0;
      r_lf_cnt   <= '0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + BUF_AW'(1);
        r_rd_cnt  <= w_rd_last ? 8'd0 : r_rd_cnt + 8'd1;
      end
      if (w_commit)  r_lf_wr <= r_lf_wr + LF_AW'(1);
      if (w_rd_last) r_lf_rd <= r_lf_rd + LF_AW'(1);
      case ({w_commit, w_rd_last})
        2'b10:   r_lf_cnt <= r_lf_cnt + (LF_AW+1)'(1);
        2'b01:   r_lf_cnt <= r_lf_cnt - (LF_AW+1)'(1);
        default: r_lf_cnt <= r_lf_cnt;
      endcase
    end
  end

  assign bus.RD_DATA   = r_rd_data;
  assign bus.RD_VALID  = r_rd_valid;
  assign bus.MSG_READY = !w_lf_empty;
  assign bus.MSG_LEN   = w_lf_empty ? 8'd0 : w_head_len;
  assign bus.TYPE_VER  = r_type_ver;
  assign bus.ERR_FMT   = r_err_fmt;
  assign bus.ERR_OVF   = r_err_ovf;
endmodule

// File: tb/tb_input_msg_framer.sv
// tb_input_msg_framer: directed messages with a read-data and event scoreboard.
// Latency: expectations queued at stimulus time, checked when RD_VALID or an event pulse appears.
// Backpressure: RD_REQ driven by the bench; extra requests while empty must produce nothing.
module tb_input_msg_framer;
  localparam logic [2:0] EV_TV  = 3'b001;
  localparam logic [2:0] EV_FMT = 3'b010;
  localparam logic [2:0] EV_OVF = 3'b100;

  logic SYS_CLK = 1'b0;
  logic RST;
  always #5 SYS_CLK = ~SYS_CLK;

  input_msg_framer_if #(.DATA_W(16)) bus ();
  input_msg_framer dut (.SYS_CLK(SYS_CLK), .RST(RST), .bus(bus));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_rdv   = 0;
  logic [15:0] exp_rd  [$];
  logic [2:0]  exp_evt [$];
  logic [15:0] msg     [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents read data or an event pulse
  always @(posedge SYS_CLK) begin
    logic [15:0] e;
    logic [2:0]  ev;
    #1;
    if (RST === 1'b1) begin
      if (bus.RD_VALID) begin
        n_rdv++;
        if (exp_rd.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_unexpected: got %0h, expected no read data", bus.RD_DATA);
        end else begin
          e = exp_rd.pop_front();
          check("rd_data", {16'h0, bus.RD_DATA}, {16'h0, e});
        end
      end
      ev = {bus.ERR_OVF, bus.ERR_FMT, bus.TYPE_VER};
      if (ev != 3'b000) begin
        if (exp_evt.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL evt_unexpected: got %b, expected no event", ev);
        end else begin
          check("event", {29'h0, ev}, {29'h0, exp_evt.pop_front()});
        end
      end
    end
  end

  task automatic send_msg(input bit commit);
    if (commit) foreach (msg[i]) exp_rd.push_back(msg[i]);
    for (int i = 0; i < msg.size(); i++) begin
      @(negedge SYS_CLK);
      bus.IN_DATA = msg[i];
      bus.IN_ENA  = 1'b1;
    end
    @(negedge SYS_CLK);
    bus.IN_ENA = 1'b0;
  endtask

  task automatic rd_n(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge SYS_CLK);
      bus.RD_REQ = 1'b1;
    end
    @(negedge SYS_CLK);
    bus.RD_REQ = 1'b0;
  endtask

  task automatic mk_0140(input logic [15:0] a, input logic [15:0] b);
    msg.delete();
    msg.push_back(16'h55AA); msg.push_back(16'h0140); msg.push_back(a); msg.push_back(b);
  endtask

  task automatic mk_len(input logic [7:0] tag, input int ndata);
    msg.delete();
    msg.push_back(16'h55AA); msg.push_back(16'h0001); msg.push_back(16'(ndata));
    for (int i = 0; i < ndata; i++) msg.push_back({tag, 8'(i)});
  endtask

  task automatic mk_0300(input logic [7:0] tag);
    msg.delete();
    msg.push_back(16'h55AA); msg.push_back(16'h0300);
    for (int i = 0; i < 16; i++) msg.push_back({tag, 8'(i)});
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_data"},   {16'h0, bus.RD_DATA}, 32'h0);
    check({tag, "_rd_valid"},  {31'h0, bus.RD_VALID}, 32'h0);
    check({tag, "_msg_ready"}, {31'h0, bus.MSG_READY}, 32'h0);
    check({tag, "_msg_len"},   {24'h0, bus.MSG_LEN}, 32'h0);
    check({tag, "_type_ver"},  {31'h0, bus.TYPE_VER}, 32'h0);
    check({tag, "_err_fmt"},   {31'h0, bus.ERR_FMT}, 32'h0);
    check({tag, "_err_ovf"},   {31'h0, bus.ERR_OVF}, 32'h0);
  endtask

  initial begin
    int base;
    RST = 1'b0;
    bus.IN_DATA = '0;
    bus.IN_ENA  = 1'b0;
    bus.RD_REQ  = 1'b0;
    repeat (3) @(negedge SYS_CLK);
    check_outputs_zero("reset");
    RST = 1'b1;

    // Fixed-length 0x0140 message, plus one surplus RD_REQ that must be ignored
    mk_0140(16'h1234, 16'h5678);
    exp_evt.push_back(EV_TV);
    send_msg(1);
    check("t1_ready", {31'h0, bus.MSG_READY}, 32'd1);
    check("t1_len", {24'h0, bus.MSG_LEN}, 32'd4);
    rd_n(5);
    check("t1_ready_after", {31'h0, bus.MSG_READY}, 32'd0);
    check("t1_len_after", {24'h0, bus.MSG_LEN}, 32'd0);

    // len + checksum message, correct checksum 0003+0002+0001+0002 = 0008
    msg = '{16'h55AA, 16'h0003, 16'h0002, 16'h0001, 16'h0002, 16'h0008};
    send_msg(1);
    check("t2_len", {24'h0, bus.MSG_LEN}, 32'd6);
    rd_n(6);
    check("t2_ready_after", {31'h0, bus.MSG_READY}, 32'd0);

    // Wrong checksum 0009
    msg = '{16'h55AA, 16'h0003, 16'h0002, 16'h0001, 16'h0002, 16'h0009};
`ifdef CHKSUM_CHECK_EN
    exp_evt.push_back(EV_FMT);
    send_msg(0);
    check("t2_badchk_ready", {31'h0, bus.MSG_READY}, 32'd0);
`else
    send_msg(1);
    check("t2_badchk_len", {24'h0, bus.MSG_LEN}, 32'd6);
    rd_n(6);
`endif

    // Garbage then an oversize len (65) -> format error, then a normal message reads clean
    msg = '{16'h1111, 16'h2222, 16'h55AA, 16'h0001, 16'h0041};
    exp_evt.push_back(EV_FMT);
    send_msg(0);
    check("t3_ready", {31'h0, bus.MSG_READY}, 32'd0);
    mk_0140(16'hAAAA, 16'hBBBB);
    exp_evt.push_back(EV_TV);
    send_msg(1);
    check("t3_len", {24'h0, bus.MSG_LEN}, 32'd4);
    rd_n(4);

    // Fill: 3 x 67 words + 5 x 4 words = 221 words, 8 queued lengths (FIFO full)
    for (int m = 0; m < 3; m++) begin
      mk_len(8'hB0 + 8'(m), 64);
      send_msg(1);
    end
    for (int k = 0; k < 5; k++) begin
      mk_0140({8'hD0, 8'(k)}, {8'hE0, 8'(k)});
      exp_evt.push_back(EV_TV);
      send_msg(1);
    end
    // Length FIFO full at commit
    mk_0300(8'hC0);
    exp_evt.push_back(EV_OVF);
    send_msg(0);
    // Buffer runs full mid-message (34 free words)
    mk_len(8'hC3, 64);
    exp_evt.push_back(EV_OVF);
    send_msg(0);
    check("t4_ready", {31'h0, bus.MSG_READY}, 32'd1);
    check("t4_len", {24'h0, bus.MSG_LEN}, 32'd67);
    base = n_rdv;
    rd_n(221);
    check("t4_words_read", n_rdv - base, 32'd221);
    check("t4_ready_after", {31'h0, bus.MSG_READY}, 32'd0);

    // Continuous reads while the next message arrives; pop and commit coincide
    mk_0140(16'hA1A1, 16'hA2A2);
    exp_evt.push_back(EV_TV);
    send_msg(1);
    mk_len(8'h77, 2);
    base = n_rdv;
    fork
      send_msg(1);
      begin
        @(negedge SYS_CLK);
        @(negedge SYS_CLK);
        bus.RD_REQ = 1'b1;
        repeat (3) @(negedge SYS_CLK);
        check("t5_len_before", {24'h0, bus.MSG_LEN}, 32'd4);
        @(negedge SYS_CLK);
        check("t5_len_switch", {24'h0, bus.MSG_LEN}, 32'd5);
        check("t5_ready_switch", {31'h0, bus.MSG_READY}, 32'd1);
        repeat (6) @(negedge SYS_CLK);
        bus.RD_REQ = 1'b0;
      end
    join
    check("t5_words_read", n_rdv - base, 32'd9);
    check("t5_ready_after", {31'h0, bus.MSG_READY}, 32'd0);

    // Reset mid-DATA loses a queued message and the partial one
    mk_0140(16'h0001, 16'h0002);
    exp_evt.push_back(EV_TV);
    send_msg(0);
    msg = '{16'h55AA, 16'h0300, 16'h0001, 16'h0002};
    send_msg(0);
    #2;
    RST = 1'b0;
    #1;
    check_outputs_zero("midrst");
    @(negedge SYS_CLK);
    RST = 1'b1;
    mk_0140(16'hCAFE, 16'hBEEF);
    exp_evt.push_back(EV_TV);
    send_msg(1);
    check("t6_len", {24'h0, bus.MSG_LEN}, 32'd4);
    rd_n(4);

    repeat (3) @(negedge SYS_CLK);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("evt_queue_drained", exp_evt.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
